// File: rtl/cache_rd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_ctrl_pkg
// Description : Shared types and constants for the 2-way cache read controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_rd_ctrl_pkg;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int WORD_W   = 32;
    localparam int LINE_W   = 128;
    localparam int BEATS    = LINE_W / WORD_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MISS   = 3'd2,
        ST_REFILL = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_BUF = 2'b00;
    localparam logic [1:0] SEL_W1  = 2'b01;
    localparam logic [1:0] SEL_W2  = 2'b10;

    // Way number (0 = way1, 1 = way2) to one-hot select/write-enable.
    function automatic logic [1:0] way_onehot(input logic way);
        return way ? SEL_W2 : SEL_W1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_lru_valid.sv
`default_nettype none
// ============================================================================
// Module      : cache_lru_valid
// Description : Per-set valid bits for both ways plus a 1-bit LRU pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_lru_valid
    import cache_rd_ctrl_pkg::*;
#(
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_valid1,
    output logic               o_valid2,
    output logic               o_lru,
    input  logic               i_upd_en,
    input  logic [INDEX_W-1:0] i_upd_idx,
    input  logic               i_upd_fill,
    input  logic               i_upd_way,
    input  logic               i_upd_lru
);

    localparam int NSETS = 1 << INDEX_W;

    logic [NSETS-1:0] r_valid1;
    logic [NSETS-1:0] r_valid2;
    logic [NSETS-1:0] r_lru;

    assign o_valid1 = r_valid1[i_rd_idx];
    assign o_valid2 = r_valid2[i_rd_idx];
    assign o_lru    = r_lru[i_rd_idx];

    // LRU bit names the next victim: 0 = way1, 1 = way2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid1 <= '0;
            r_valid2 <= '0;
            r_lru    <= '0;
        end else if (i_upd_en) begin
            r_lru[i_upd_idx] <= i_upd_lru;
            if (i_upd_fill) begin
                if (i_upd_way) r_valid2[i_upd_idx] <= 1'b1;
                else           r_valid1[i_upd_idx] <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_rd_ctrl
// Description : 2-way set-associative cache read controller with line refill.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_rd_ctrl
    import cache_rd_ctrl_pkg::*;
#(
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [ADDR_W-1:0]  req_addr,
    output logic               req_ready,
    output logic               resp_valid,
    output logic [INDEX_W-1:0] ram_index,
    input  logic [TAG_W-1:0]   tag1,
    input  logic [TAG_W-1:0]   tag2,
    output logic [1:0]         hit,
    output logic [OFFSET_W-1:0] offset,
    output logic [LINE_W-1:0]  m_data,
    output logic [1:0]         way_we,
    output logic [TAG_W-1:0]   tag_wdata,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic               mem_rvalid,
    input  logic [WORD_W-1:0]  mem_rdata,
    input  logic               mem_rlast
);

    localparam int CNT_W = $clog2(BEATS);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_victim;
    logic [CNT_W-1:0]    r_cnt;
    logic [LINE_W-1:0]   r_mdata;
    logic                r_mem_req;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [1:0]          r_way_we;
    logic [TAG_W-1:0]    r_tag_wdata;

    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_idx;
    logic                w_valid1;
    logic                w_valid2;
    logic                w_lru;
    logic                w_lookup;
    logic                w_done;
    logic                w_h1;
    logic                w_h2;
    logic                w_hit;
    logic                w_accept;
    logic                w_victim;
    logic                w_upd_en;
    logic                w_upd_lru;

    assign w_tag    = r_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    assign w_idx    = r_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign w_lookup = (r_state == ST_LOOKUP);
    assign w_done   = (r_state == ST_DONE);

    // Tag RAM data is valid in LOOKUP, one cycle after the index was driven.
    assign w_h1     = w_valid1 && (tag1 == w_tag);
    assign w_h2     = w_valid2 && (tag2 == w_tag);
    assign w_hit    = w_h1 || w_h2;
    assign w_victim = !w_valid1 ? 1'b0 : (!w_valid2 ? 1'b1 : w_lru);

    assign req_ready  = !rst && ((r_state == ST_IDLE) || (w_lookup && w_hit));
    assign w_accept   = req_valid && req_ready;
    assign ram_index  = w_accept ? req_addr[INDEX_W+OFFSET_W-1:OFFSET_W] : w_idx;

    assign resp_valid = (w_lookup && w_hit) || w_done;
    assign hit        = (w_lookup && w_h1) ? SEL_W1 :
                        (w_lookup && w_h2) ? SEL_W2 : SEL_BUF;
    assign offset     = resp_valid ? r_addr[OFFSET_W-1:0] : '0;
    assign m_data     = r_mdata;
    assign way_we     = r_way_we;
    assign tag_wdata  = r_tag_wdata;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;

    // A hit points LRU at the other way; a refill marks the victim valid and does the same.
    assign w_upd_en  = (w_lookup && w_hit) || w_done;
    assign w_upd_lru = w_lookup ? w_h1 : !r_victim;

    cache_lru_valid #(
        .INDEX_W (INDEX_W)
    ) u_lru_valid (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (w_idx),
        .o_valid1   (w_valid1),
        .o_valid2   (w_valid2),
        .o_lru      (w_lru),
        .i_upd_en   (w_upd_en),
        .i_upd_idx  (w_idx),
        .i_upd_fill (w_done),
        .i_upd_way  (r_victim),
        .i_upd_lru  (w_upd_lru)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_victim    <= 1'b0;
            r_cnt       <= '0;
            r_mdata     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_way_we    <= '0;
            r_tag_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_state <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (w_hit) begin
                        if (w_accept) r_addr  <= req_addr;
                        else          r_state <= ST_IDLE;
                    end else begin
                        r_victim   <= w_victim;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {r_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        r_state    <= ST_MISS;
                    end
                end
                ST_MISS: begin
                    if (mem_ready) begin
                        r_mem_req  <= 1'b0;
                        r_mem_addr <= '0;
                        r_cnt      <= '0;
                        r_state    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (mem_rvalid) begin
                        r_mdata[r_cnt*WORD_W +: WORD_W] <= mem_rdata;
                        r_cnt <= r_cnt + 1'b1;
                        if (mem_rlast) begin
                            r_way_we    <= way_onehot(r_victim);
                            r_tag_wdata <= w_tag;
                            r_state     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_way_we    <= '0;
                    r_tag_wdata <= '0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_rd_ctrl
// Description : Self-checking bench for cache_rd_ctrl with RAM and memory models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_rd_ctrl;

    localparam int INDEX_W = 8;
    localparam int TAG_W   = 20;
    localparam int NSETS   = 1 << INDEX_W;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic [31:0]        req_addr;
    logic               req_ready;
    logic               resp_valid;
    logic [INDEX_W-1:0] ram_index;
    logic [TAG_W-1:0]   tag1;
    logic [TAG_W-1:0]   tag2;
    logic [1:0]         hit;
    logic [3:0]         offset;
    logic [127:0]       m_data;
    logic [1:0]         way_we;
    logic [TAG_W-1:0]   tag_wdata;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               mem_rlast;

    always #5 clk = ~clk;

    cache_rd_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .resp_valid(resp_valid), .ram_index(ram_index),
        .tag1(tag1), .tag2(tag2), .hit(hit), .offset(offset), .m_data(m_data),
        .way_we(way_we), .tag_wdata(tag_wdata), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rlast(mem_rlast)
    );

    // External tag/data RAMs: one-cycle read, written by the refill port.
    logic [TAG_W-1:0] tram1 [NSETS];
    logic [TAG_W-1:0] tram2 [NSETS];
    logic [127:0]     dram1 [NSETS];
    logic [127:0]     dram2 [NSETS];
    always @(posedge clk) begin
        if (way_we[0]) begin tram1[ram_index] <= tag_wdata; dram1[ram_index] <= m_data; end
        if (way_we[1]) begin tram2[ram_index] <= tag_wdata; dram2[ram_index] <= m_data; end
        tag1 <= tram1[ram_index];
        tag2 <= tram2[ram_index];
    end

    // Reference: backing memory lines and per-set residency with recency.
    logic [127:0]     gmem [logic [31:0]];
    bit               m_v  [2][NSETS];
    logic [TAG_W-1:0] m_t  [2][NSETS];
    int               m_mru [NSETS];

    int n_checks = 0;
    int n_fail   = 0;

    int           obs_lat, obs_nresp, obs_gaps;
    bit           obs_timeout, obs_bad, obs_mem_seen;
    logic [1:0]   obs_hit, obs_way_we;
    logic [3:0]   obs_offset;
    logic [31:0]  obs_mem_addr, obs_word;
    logic [TAG_W-1:0] obs_tag_wdata;
    logic [127:0] obs_mdata;
    int           exp_way, exp_victim;
    logic [1:0]   exp_sel, exp_we;
    logic [31:0]  exp_word, exp_line;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void model_lookup(input int idx, input logic [TAG_W-1:0] tg,
                                         output int way, output int vict);
        way = 0;
        if (m_v[0][idx] && m_t[0][idx] == tg)      way = 1;
        else if (m_v[1][idx] && m_t[1][idx] == tg) way = 2;
        if (!m_v[0][idx])      vict = 0;
        else if (!m_v[1][idx]) vict = 1;
        else                   vict = (m_mru[idx] == 0) ? 1 : 0;
    endfunction

    function automatic void model_update(input int idx, input logic [TAG_W-1:0] tg,
                                         input int way, input int vict);
        if (way != 0) begin
            m_mru[idx] = way - 1;
        end else begin
            m_v[vict][idx] = 1'b1;
            m_t[vict][idx] = tg;
            m_mru[idx]     = vict;
        end
    endfunction

    // Drives one read to completion, serving any refill; records observations and expectations.
    task automatic do_read(input logic [31:0] addr, input int stall, input int gmin, input int gmax);
        int n, g, idx;
        logic [TAG_W-1:0] tg;
        logic [127:0] ln, sl;
        exp_line = {addr[31:4], 4'h0};
        idx = int'(addr[INDEX_W+3:4]);
        tg  = addr[31:INDEX_W+4];
        if (!gmem.exists(exp_line)) gmem[exp_line] = {$urandom, $urandom, $urandom, $urandom};
        ln = gmem[exp_line];
        exp_word = ln[addr[3:2]*32 +: 32];
        model_lookup(idx, tg, exp_way, exp_victim);
        exp_sel = (exp_way == 1) ? 2'b01 : (exp_way == 2) ? 2'b10 : 2'b00;
        exp_we  = (exp_way != 0) ? 2'b00 : (exp_victim == 1 ? 2'b10 : 2'b01);
        obs_timeout = 0; obs_bad = 0; obs_mem_seen = 0; obs_nresp = 0; obs_lat = 0; obs_gaps = 0;
        obs_hit = 2'bxx; obs_way_we = 2'b00; obs_offset = 4'hx; obs_mem_addr = 32'h0;
        obs_word = 32'hx; obs_tag_wdata = '0; obs_mdata = '0;
        req_valid = 1'b1; req_addr = addr; #1;
        n = 0;
        while (!req_ready && n < 20) begin tick; n++; end
        if (!req_ready) begin obs_timeout = 1; req_valid = 1'b0; return; end
        tick;
        req_valid = 1'b0; req_addr = $urandom; #1;
        obs_lat = 1;
        if (resp_valid === 1'b1) begin
            obs_nresp = 1; obs_hit = hit; obs_offset = offset; obs_way_we = way_we;
            obs_mem_seen = mem_req;
            sl = (hit == 2'b10) ? dram2[idx] : dram1[idx];
            obs_word = sl[offset[3:2]*32 +: 32];
            tick;
            if (resp_valid !== 1'b0) obs_bad = 1;
        end else begin
            tick; obs_lat++;
            obs_mem_seen = mem_req; obs_mem_addr = mem_addr;
            for (int s = 0; s < stall; s++) begin
                if (mem_req !== 1'b1 || mem_addr !== obs_mem_addr || resp_valid !== 1'b0 || way_we !== 2'b00)
                    obs_bad = 1;
                tick; obs_lat++;
            end
            mem_ready = 1'b1; #1;
            if (mem_req !== 1'b1 || mem_addr !== obs_mem_addr) obs_bad = 1;
            tick; obs_lat++;
            mem_ready = 1'b0;
            for (int b = 0; b < 4; b++) begin
                g = $urandom_range(gmin, gmax);
                obs_gaps += g;
                for (int k = 0; k < g; k++) begin
                    mem_rvalid = 1'b0; mem_rdata = $urandom; mem_rlast = 1'($urandom_range(0, 1)); #1;
                    if (resp_valid !== 1'b0 || way_we !== 2'b00 || mem_req !== 1'b0) obs_bad = 1;
                    tick; obs_lat++;
                end
                mem_rvalid = 1'b1; mem_rdata = ln[b*32 +: 32]; mem_rlast = (b == 3); #1;
                if (resp_valid !== 1'b0 || way_we !== 2'b00 || mem_req !== 1'b0) obs_bad = 1;
                tick; obs_lat++;
            end
            mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
            obs_nresp = (resp_valid === 1'b1) ? 1 : 0;
            obs_hit = hit; obs_offset = offset; obs_way_we = way_we;
            obs_tag_wdata = tag_wdata; obs_mdata = m_data;
            obs_word = m_data[offset[3:2]*32 +: 32];
            tick;
            if (resp_valid !== 1'b0 || way_we !== 2'b00) obs_bad = 1;
        end
        model_update(idx, tg, exp_way, exp_victim);
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
        tick; tick;
        n_checks++;
        if ({req_ready, resp_valid, hit, offset, way_we, mem_req, ram_index} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b exp=0", {req_ready, resp_valid, hit, offset, way_we, mem_req, ram_index});
        end
        n_checks++;
        if (m_data !== '0) begin n_fail++; $display("FAIL reset_mdata got=%h exp=0", m_data); end
        n_checks++;
        if (mem_addr !== '0 || tag_wdata !== '0) begin
            n_fail++; $display("FAIL reset_addr got=%h/%h exp=0/0", mem_addr, tag_wdata);
        end
        rst = 1'b0; #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL idle_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_cold_miss;
        gmem[32'h0000_1230] = {32'hD, 32'hC, 32'hB, 32'hA};
        do_read(32'h0000_1234, 0, 0, 0);
        n_checks++;
        if (obs_timeout || obs_mem_addr !== 32'h0000_1230) begin
            n_fail++; $display("FAIL cold_mem_addr got=%h exp=00001230", obs_mem_addr);
        end
        n_checks++;
        if (obs_way_we !== 2'b01 || obs_tag_wdata !== 20'h00001) begin
            n_fail++; $display("FAIL cold_write got=%b/%h exp=01/00001", obs_way_we, obs_tag_wdata);
        end
        n_checks++;
        if (obs_nresp !== 1 || obs_hit !== 2'b00 || obs_offset !== 4'h4) begin
            n_fail++; $display("FAIL cold_resp got=%0d/%b/%h exp=1/00/4", obs_nresp, obs_hit, obs_offset);
        end
        n_checks++;
        if (obs_mdata[63:32] !== 32'hB) begin n_fail++; $display("FAIL cold_word1 got=%h exp=b", obs_mdata[63:32]); end
        n_checks++;
        if (obs_lat !== 7 || obs_bad) begin n_fail++; $display("FAIL cold_latency got=%0d bad=%0b exp=7", obs_lat, obs_bad); end
    endtask

    task automatic test_hit_after_fill;
        do_read(32'h0000_1238, 0, 0, 0);
        n_checks++;
        if (obs_lat !== 1 || obs_hit !== 2'b01 || obs_offset !== 4'h8) begin
            n_fail++; $display("FAIL hit_resp got=lat%0d/%b/%h exp=lat1/01/8", obs_lat, obs_hit, obs_offset);
        end
        n_checks++;
        if (obs_mem_seen || obs_way_we !== 2'b00 || obs_bad) begin
            n_fail++; $display("FAIL hit_no_mem got=%b/%b exp=0/00", obs_mem_seen, obs_way_we);
        end
        n_checks++;
        if (obs_word !== 32'hC) begin n_fail++; $display("FAIL hit_word got=%h exp=c", obs_word); end
    endtask

    task automatic test_conflict_lru;
        do_read(32'h0001_1230, 0, 0, 1);
        n_checks++;
        if (obs_way_we !== 2'b10) begin n_fail++; $display("FAIL conf_fill2 got=%b exp=10", obs_way_we); end
        do_read(32'h0000_1230, 0, 0, 0);
        n_checks++;
        if (obs_hit !== 2'b01 || obs_mem_seen) begin n_fail++; $display("FAIL conf_hit1 got=%b exp=01", obs_hit); end
        do_read(32'h0002_1230, 0, 0, 1);
        n_checks++;
        if (obs_way_we !== 2'b10 || obs_hit !== 2'b00) begin
            n_fail++; $display("FAIL conf_victim got=%b exp=10", obs_way_we);
        end
        do_read(32'h0001_1230, 0, 0, 0);
        n_checks++;
        if (!obs_mem_seen || obs_way_we !== 2'b01 || obs_word !== exp_word) begin
            n_fail++; $display("FAIL conf_evicted got=req%b/%b exp=req1/01", obs_mem_seen, obs_way_we);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0]  a [4];
        logic [127:0] ln, sl;
        int way, vict;
        a[0] = 32'h0000_5000; a[1] = 32'h0000_5008; a[2] = 32'h0000_5014; a[3] = 32'h0000_501C;
        do_read(32'h0000_5000, 0, 0, 0);
        do_read(32'h0000_5010, 0, 0, 0);
        req_valid = 1'b1; req_addr = a[0]; #1;
        tick;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) req_addr = a[i+1];
            else       req_valid = 1'b0;
            #1;
            ln = gmem[{a[i][31:4], 4'h0}];
            sl = dram1[a[i][11:4]];
            n_checks++;
            if (resp_valid !== 1'b1 || hit !== 2'b01 || offset !== a[i][3:0] ||
                sl[a[i][3:2]*32 +: 32] !== ln[a[i][3:2]*32 +: 32]) begin
                n_fail++;
                $display("FAIL b2b_resp%0d got=%b/%b/%h exp=1/01/%h", i, resp_valid, hit, offset, a[i][3:0]);
            end
            if (i < 3) begin
                n_checks++;
                if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d got=%b exp=1", i, req_ready); end
            end
            model_lookup(int'(a[i][11:4]), a[i][31:12], way, vict);
            model_update(int'(a[i][11:4]), a[i][31:12], way, vict);
            tick;
        end
        n_checks++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b exp=0", resp_valid); end
    endtask

    task automatic test_mem_stall;
        do_read(32'h0000_3404, 5, 1, 3);
        n_checks++;
        if (obs_mem_addr !== 32'h0000_3400 || obs_bad) begin
            n_fail++; $display("FAIL stall_req got=%h bad=%0b exp=00003400", obs_mem_addr, obs_bad);
        end
        n_checks++;
        if (obs_mdata !== gmem[32'h0000_3400] || obs_word !== exp_word) begin
            n_fail++; $display("FAIL stall_line got=%h exp=%h", obs_mdata, gmem[32'h0000_3400]);
        end
        n_checks++;
        if (obs_nresp !== 1 || obs_lat !== 5 + obs_gaps + 7) begin
            n_fail++; $display("FAIL stall_resp got=%0d/lat%0d exp=1/lat%0d", obs_nresp, obs_lat, 5 + obs_gaps + 7);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 120; i++) begin
            logic [19:0] tg;
            logic [7:0]  ix;
            logic [3:0]  of;
            tg = 20'h00010 + 20'($urandom_range(0, 2));
            ix = 8'h60 + 8'($urandom_range(0, 1));
            of = 4'($urandom_range(0, 15));
            do_read({tg, ix, of}, $urandom_range(0, 2), 0, 2);
            n_checks++;
            if (obs_timeout || obs_nresp !== 1 || obs_bad || obs_hit !== exp_sel || obs_offset !== of) begin
                n_fail++;
                $display("FAIL rnd_resp%0d got=%0d/%b/%h bad=%0b exp=1/%b/%h", i, obs_nresp, obs_hit, obs_offset, obs_bad, exp_sel, of);
            end
            n_checks++;
            if (obs_way_we !== exp_we || obs_word !== exp_word) begin
                n_fail++; $display("FAIL rnd_data%0d got=%b/%h exp=%b/%h", i, obs_way_we, obs_word, exp_we, exp_word);
            end
            n_checks++;
            if (obs_mem_seen !== (exp_way == 0) || (exp_way == 0 && obs_mem_addr !== exp_line)) begin
                n_fail++; $display("FAIL rnd_mem%0d got=%b/%h exp=%b/%h", i, obs_mem_seen, obs_mem_addr, exp_way == 0, exp_line);
            end
        end
    endtask

    task automatic test_reset_mid_refill;
        logic [31:0]  a;
        logic [127:0] ln;
        bit bad;
        a  = 32'h0007_7778;
        ln = {$urandom, $urandom, $urandom, $urandom};
        gmem[32'h0007_7770] = ln;
        req_valid = 1'b1; req_addr = a; #1;
        tick;
        req_valid = 1'b0; tick;
        mem_ready = 1'b1; tick; mem_ready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            mem_rvalid = 1'b1; mem_rdata = ln[b*32 +: 32]; mem_rlast = 1'b0; tick;
        end
        mem_rvalid = 1'b0; #1;
        n_checks++;
        if (m_data[63:0] !== ln[63:0]) begin n_fail++; $display("FAIL mid_beats got=%h exp=%h", m_data[63:0], ln[63:0]); end
        rst = 1'b1; tick;
        n_checks++;
        if (way_we !== 2'b00 || resp_valid !== 1'b0 || mem_req !== 1'b0 || m_data !== '0) begin
            n_fail++; $display("FAIL mid_reset got=%b/%b/%b/%h exp=00/0/0/0", way_we, resp_valid, mem_req, m_data);
        end
        tick; rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            mem_rvalid = 1'b1; mem_rlast = 1'b1; mem_rdata = $urandom; #1;
            if (way_we !== 2'b00 || resp_valid !== 1'b0) bad = 1;
            tick;
        end
        mem_rvalid = 1'b0; mem_rlast = 1'b0; #1;
        n_checks++;
        if (bad || m_data !== '0) begin n_fail++; $display("FAIL mid_stray got=bad%0b/%h exp=0/0", bad, m_data); end
        for (int s = 0; s < NSETS; s++) begin m_v[0][s] = 1'b0; m_v[1][s] = 1'b0; m_mru[s] = 0; end
        do_read(a, 0, 0, 1);
        n_checks++;
        if (!obs_mem_seen || obs_way_we !== 2'b01 || obs_nresp !== 1 || obs_word !== ln[95:64]) begin
            n_fail++; $display("FAIL mid_remiss got=req%b/%b/%h exp=req1/01/%h", obs_mem_seen, obs_way_we, obs_word, ln[95:64]);
        end
    endtask

    initial begin
        for (int s = 0; s < NSETS; s++) begin m_v[0][s] = 1'b0; m_v[1][s] = 1'b0; m_mru[s] = 0; end
        test_reset;
        test_cold_miss;
        test_hit_after_fill;
        test_conflict_lru;
        test_back_to_back;
        test_mem_stall;
        test_random;
        test_reset_mid_refill;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
